tile_frame_buffer: RTL and testbench

TILE_FRAME_BUFFER -- requirements
Module: tile_frame_buffer

---
 rtl/tfb_pkg.sv | 21 ++
 rtl/bram_sdp.sv | 38 +++
 rtl/tile_frame_buffer.sv | 182 ++++++++++++++++++
 tb/tb_tile_frame_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tfb_pkg.sv
// -----------------------------------------------------------------------------
// tfb_pkg
// Shared constants for the tile frame buffer:
//   - FSM state encoding (WRITE / READ)
//   - readout mode constants (MODE_RASTER / MODE_TILE)
//   - clog2Min1: $clog2 that never returns a zero width, for counters whose
//     range may collapse to a single value with some parameter choices
// -----------------------------------------------------------------------------
package tfb_pkg;

  localparam logic [0:0] ST_WRITE = 1'b0;
  localparam logic [0:0] ST_READ  = 1'b1;

  localparam logic MODE_RASTER = 1'b0;
  localparam logic MODE_TILE   = 1'b1;

  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// -----------------------------------------------------------------------------
// bram_sdp
// Simple dual-port RAM: one write port, one read port, single clock, read data
// registered once (1-cycle read latency). Written in the plain style that
// synthesis tools map onto block RAM.
// Ports:
//   iClk     clock
//   iWrEn    write enable
//   iWrAddr  write address
//   iWrData  write data
//   iRdEn    read enable (read register updates only when set)
//   iRdAddr  read address
//   oRdData  registered read data
// -----------------------------------------------------------------------------
module bram_sdp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              iClk,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: neither the array nor the read register has a reset; a reset would
  // stop the array mapping onto block RAM, and frame contents survive reset.
  always_ff @(posedge iClk) begin
    if (iWrEn) mem[iWrAddr] <= iWrData;
    if (iRdEn) oRdData <= mem[iRdAddr];
  end

endmodule

// File: rtl/tile_frame_buffer.sv
// -----------------------------------------------------------------------------
// tile_frame_buffer
// Captures one raster-order frame, then reads it back either in raster order
// or tile by tile (tiles left to right, top to bottom; raster inside a tile).
// WRITE state accepts pixels (gaps allowed); the last pixel latches iMode and
// moves to READ, which issues one address per cycle for a whole frame.
// Ports:
//   iClk        clock
//   iRst        synchronous active-high reset
//   iValid      input pixel qualifier
//   iData       input pixel (raster order)
//   iMode       readout order, sampled on the last write (0 raster, 1 tile)
//   oValid      output pixel qualifier (2 cycles after address issue)
//   oData       output pixel, holds when oValid is low
//   oBusy       high while in READ
//   oFrameDone  pulses with the final pixel of a readout
//   oOverflow   pulses when an input pixel arrives during READ and is dropped
// -----------------------------------------------------------------------------
module tile_frame_buffer
  import tfb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 16,
  parameter int TILE_W = 16,
  parameter int TILE_H = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  input  logic              iMode,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oOverflow
);

  localparam int PIX    = IMG_W * IMG_H;
  localparam int ADDR_W = clog2Min1(PIX);
  localparam int TX_N   = IMG_W / TILE_W;
  localparam int TY_N   = IMG_H / TILE_H;
  localparam int C_W    = clog2Min1(TILE_W);
  localparam int R_W    = clog2Min1(TILE_H);
  localparam int TX_W   = clog2Min1(TX_N);
  localparam int TY_W   = clog2Min1(TY_N);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);
  localparam logic [C_W-1:0]    C_LAST    = C_W'(TILE_W - 1);
  localparam logic [R_W-1:0]    R_LAST    = R_W'(TILE_H - 1);
  localparam logic [TX_W-1:0]   TX_LAST   = TX_W'(TX_N - 1);

  if ((IMG_W % TILE_W) != 0 || (IMG_H % TILE_H) != 0) begin : gBadTile
    $error("tile_frame_buffer: frame size must be a whole number of tiles");
  end

  logic [0:0]        state;
  logic              modeLat;
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] rdCnt;
  logic [C_W-1:0]    cCnt;
  logic [R_W-1:0]    rCnt;
  logic [TX_W-1:0]   txCnt;
  logic [TY_W-1:0]   tyCnt;
  logic [ADDR_W-1:0] tileAddr;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] ramData;
  logic              wrEn;
  logic              rdEn;
  logic              issueLast;
  logic              vld1;
  logic              last1;

  // Reset wins over a same-cycle write or drop report.
  assign wrEn      = !iRst && (state == ST_WRITE) && iValid;
  assign rdEn      = (state == ST_READ);
  assign issueLast = (rdCnt == LAST_ADDR);
  assign oBusy     = (state == ST_READ);
  assign oOverflow = !iRst && (state == ST_READ) && iValid;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    rdAddr   = rdCnt;
    tileAddr = ADDR_W'((int'(tyCnt) * TILE_H + int'(rCnt)) * IMG_W
                       + int'(txCnt) * TILE_W + int'(cCnt));
    if (modeLat == MODE_TILE) rdAddr = tileAddr;
  end

  // rdCnt counts issued reads in both modes and ends the frame; the tile
  // counters run alongside it and only matter in tile mode.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= ST_WRITE;
      wa      <= '0;
      modeLat <= MODE_RASTER;
      rdCnt   <= '0;
      cCnt    <= '0;
      rCnt    <= '0;
      txCnt   <= '0;
      tyCnt   <= '0;
    end else begin
      case (state)
        ST_WRITE: begin
          if (iValid) begin
            if (wa == LAST_ADDR) begin
              wa      <= '0;
              modeLat <= iMode;
              state   <= ST_READ;
            end else begin
              wa <= wa + 1'b1;
            end
          end
        end
        default: begin
          if (issueLast) begin
            state <= ST_WRITE;
            rdCnt <= '0;
            cCnt  <= '0;
            rCnt  <= '0;
            txCnt <= '0;
            tyCnt <= '0;
          end else begin
            rdCnt <= rdCnt + 1'b1;
            if (cCnt == C_LAST) begin
              cCnt <= '0;
              if (rCnt == R_LAST) begin
                rCnt <= '0;
                if (txCnt == TX_LAST) begin
                  txCnt <= '0;
                  tyCnt <= tyCnt + 1'b1;
                end else begin
                  txCnt <= txCnt + 1'b1;
                end
              end else begin
                rCnt <= rCnt + 1'b1;
              end
            end else begin
              cCnt <= cCnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  bram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (PIX),
    .ADDR_W (ADDR_W)
  ) uRam (
    .iClk    (iClk),
    .iWrEn   (wrEn),
    .iWrAddr (wa),
    .iWrData (iData),
    .iRdEn   (rdEn),
    .iRdAddr (rdAddr),
    .oRdData (ramData)
  );

  // Valid/last travel beside the data: stage 1 matches the RAM read register,
  // stage 2 is the output register. Clearing them on reset aborts a frame.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld1       <= 1'b0;
      last1      <= 1'b0;
      oValid     <= 1'b0;
      oFrameDone <= 1'b0;
      oData      <= '0;
    end else begin
      vld1       <= rdEn;
      last1      <= rdEn && issueLast;
      oValid     <= vld1;
      oFrameDone <= last1;
      if (vld1) oData <= ramData;
    end
  end

endmodule

// File: tb/tb_tile_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_tile_frame_buffer
// Randomised bench for tile_frame_buffer. The driver keeps a frame-level
// reference (pixel array, write pointer, remaining read cycles) and, when a
// frame completes, lists its expected readout in raster or tile order. Each
// READ cycle moves one expected pixel into a scoreboard stamped with the cycle
// it must appear in; an independent monitor pops and compares on oValid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tile_frame_buffer;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 16;
  localparam int TILE_W = 16;
  localparam int TILE_H = 16;
  localparam int PIX    = IMG_W * IMG_H;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iValid;
  logic [DATA_W-1:0] iData;
  logic              iMode;
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic              oBusy;
  logic              oFrameDone;
  logic              oOverflow;

  tile_frame_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iValid     (iValid),
    .iData      (iData),
    .iMode      (iMode),
    .oValid     (oValid),
    .oData      (oData),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone),
    .oOverflow  (oOverflow)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
    int                due;
  } exp_t;

  exp_t              sb[$];
  exp_t              pend[$];
  exp_t              monE;
  logic [DATA_W-1:0] refMem [PIX];
  int                wa       = 0;
  int                readLeft = 0;
  int                cyc      = 0;
  int                clrAtCyc = -1;
  int                passCnt  = 0;
  int                totalCnt = 0;
  bit                monEn    = 1'b0;
  bit                expBusy  = 1'b0;
  bit                expOvf   = 1'b0;
  logic [DATA_W-1:0] lastSeen = '0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void pushPend(input int addr);
    exp_t e;
    e.data = refMem[addr];
    e.last = (pend.size() == PIX - 1);
    e.due  = 0;
    pend.push_back(e);
  endfunction

  // Expected readout order for a completed frame.
  function automatic void latchFrame(input bit tileMode);
    pend.delete();
    if (tileMode) begin
      for (int ty = 0; ty < IMG_H / TILE_H; ty++)
        for (int tx = 0; tx < IMG_W / TILE_W; tx++)
          for (int r = 0; r < TILE_H; r++)
            for (int c = 0; c < TILE_W; c++)
              pushPend((ty * TILE_H + r) * IMG_W + tx * TILE_W + c);
    end else begin
      for (int n = 0; n < PIX; n++) pushPend(n);
    end
  endfunction

  // Drives one cycle of inputs (called just after a rising edge) and applies
  // the reference for what the DUT does with them during this cycle.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit m, input bit rst);
    exp_t e;
    iValid = v;
    iData  = d;
    iMode  = m;
    iRst   = rst;
    expBusy = (readLeft > 0);
    expOvf  = !rst && v && (readLeft > 0);
    if (rst) begin
      readLeft = 0;
      wa       = 0;
      pend.delete();
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      clrAtCyc = cyc + 1;
    end else if (readLeft > 0) begin
      e     = pend.pop_front();
      e.due = cyc + 2;
      sb.push_back(e);
      readLeft--;
    end else if (v) begin
      refMem[wa] = d;
      wa++;
      if (wa == PIX) begin
        wa = 0;
        latchFrame(m);
        readLeft = PIX;
      end
    end
    @(posedge iClk);
    #1;
  endtask

  // modeSel: 0 raster, 1 tile, 2 random per write (last write decides).
  // gapSel: 0 contiguous, 1 alternate idle, 2 random idle runs.
  task automatic sendFrame(input int modeSel, input int gapSel, input bit flood,
                           input bit randData, input int rstAt);
    for (int k = 0; k < PIX; k++) begin
      bit m;
      logic [DATA_W-1:0] d;
      m = (modeSel == 2) ? 1'($urandom) : 1'(modeSel);
      d = randData ? DATA_W'($urandom) : DATA_W'(k);
      cycle(1'b1, d, m, 1'b0);
      if (gapSel == 1) cycle(1'b0, DATA_W'($urandom), m, 1'b0);
      else if (gapSel == 2) repeat ($urandom_range(0, 2)) cycle(1'b0, DATA_W'($urandom), m, 1'b0);
    end
    for (int i = 0; i < PIX; i++) begin
      if (i == rstAt) begin
        cycle(1'b0, DATA_W'($urandom), 1'($urandom), 1'b1);
        break;
      end
      cycle(flood, DATA_W'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  always @(negedge iClk) begin
    if (monEn) begin
      if (cyc == clrAtCyc) lastSeen = '0;
      check("busy", oBusy, expBusy);
      check("overflow", oOverflow, expOvf);
      if (oValid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", oValid, 0);
        end else begin
          monE = sb.pop_front();
          check("data", oData, monE.data);
          check("frame_done", oFrameDone, monE.last);
          check("latency", cyc, monE.due);
          lastSeen = monE.data;
        end
      end else begin
        check("frame_done_idle", oFrameDone, 0);
        check("data_hold", oData, lastSeen);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_valid", oValid, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    iRst   = 1'b1;
    iValid = 1'b1;
    iData  = '1;
    iMode  = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_valid", oValid, 0);
    check("rst_busy", oBusy, 0);
    check("rst_frame_done", oFrameDone, 0);
    check("rst_overflow", oOverflow, 0);
    check("rst_data", oData, 0);
    @(posedge iClk);
    #1;
    monEn = 1'b1;

    sendFrame(1, 0, 1'b0, 1'b0, -1);   // tile order, pixel k = k[7:0]
    sendFrame(0, 0, 1'b0, 1'b0, -1);   // raster order
    sendFrame(1, 1, 1'b0, 1'b0, -1);   // valid toggling 1,0,1,0
    sendFrame(0, 0, 1'b1, 1'b1, -1);   // inputs held high through READ
    sendFrame(1, 2, 1'b0, 1'b1, -1);   // next frame after overflow, random gaps
    sendFrame(1, 0, 1'b0, 1'b0, 102);  // reset while pixel 100 is on the output
    sendFrame(0, 0, 1'b0, 1'b1, -1);   // fresh frame after reset
    sendFrame(2, 2, 1'b0, 1'b1, -1);   // mode toggling during writes

    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check("drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
